// File: rtl/id_pkg.sv
// Shared decode constants, control bundle and the combinational decode,
// condition-check and RAW-hazard helpers for the ARM ID stage.
package id_pkg;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010,
                           OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110,
                           OP_TST = 4'b1000, OP_CMP = 4'b1010, OP_ORR = 4'b1100,
                           OP_MOV = 4'b1101, OP_MVN = 4'b1111;

    localparam logic [3:0] CMD_MOV = 4'b0001, CMD_ADD = 4'b0010, CMD_ADC = 4'b0011,
                           CMD_SUB = 4'b0100, CMD_SBC = 4'b0101, CMD_AND = 4'b0110,
                           CMD_ORR = 4'b0111, CMD_EOR = 4'b1000, CMD_MVN = 4'b1001;

    localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                           COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                           COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
                           COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

    // Hazard helper compares indices at this fixed width; callers zero-extend.
    localparam int IDX_W = 8;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       branch;
        logic       s;
        logic [3:0] cmd;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[27:26])
            MODE_DP: begin
                c.wb_en = 1'b1;
                c.s     = instr[20];
                case (instr[24:21])
                    OP_MOV: c.cmd = CMD_MOV;
                    OP_MVN: c.cmd = CMD_MVN;
                    OP_ADD: c.cmd = CMD_ADD;
                    OP_ADC: c.cmd = CMD_ADC;
                    OP_SUB: c.cmd = CMD_SUB;
                    OP_SBC: c.cmd = CMD_SBC;
                    OP_AND: c.cmd = CMD_AND;
                    OP_ORR: c.cmd = CMD_ORR;
                    OP_EOR: c.cmd = CMD_EOR;
                    OP_CMP: begin c.cmd = CMD_SUB; c.wb_en = 1'b0; end
                    OP_TST: begin c.cmd = CMD_AND; c.wb_en = 1'b0; end
                    default: c = '0;
                endcase
            end
            MODE_MEM: begin
                c.cmd = CMD_ADD;
                if (instr[20]) begin
                    c.mem_read = 1'b1;
                    c.wb_en    = 1'b1;
                end else begin
                    c.mem_write = 1'b1;
                end
            end
            MODE_BR: c.branch = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // nzcv = {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, cy, v;
        {n, z, cy, v} = nzcv;
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return cy;
            COND_CC: return ~cy;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return cy & ~z;
            COND_LS: return ~cy | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_str(input logic [31:0] instr);
        return (instr[27:26] == MODE_MEM) && !instr[20];
    endfunction

    function automatic logic uses_rn(input logic [31:0] instr);
        logic is_mov;
        is_mov = (instr[27:26] == MODE_DP) &&
                 ((instr[24:21] == OP_MOV) || (instr[24:21] == OP_MVN));
        return !(is_mov || (instr[27:26] == MODE_BR));
    endfunction

    function automatic logic two_src(input logic [31:0] instr);
        return !instr[25] || is_str(instr);
    endfunction

    function automatic logic raw_hazard(input logic             use1,
                                        input logic             use2,
                                        input logic [IDX_W-1:0] src1,
                                        input logic [IDX_W-1:0] src2,
                                        input logic             exe_wb,
                                        input logic [IDX_W-1:0] exe_dest,
                                        input logic             mem_wb,
                                        input logic [IDX_W-1:0] mem_dest);
        logic m1, m2;
        m1 = (exe_wb && exe_dest == src1) || (mem_wb && mem_dest == src1);
        m2 = (exe_wb && exe_dest == src2) || (mem_wb && mem_dest == src2);
        return (use1 && m1) || (use2 && m2);
    endfunction

endpackage

// File: rtl/id_stage_piped_reg_file_bypass.sv
// Register file with synchronous reset/write and combinational read ports
// that forward a same-cycle write.
module reg_file_bypass #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REGS        = 16,
    parameter int RESET_REG_INDEX = 1,
    localparam int REG_AW = ($clog2(NUM_REGS) < 4) ? 4 : $clog2(NUM_REGS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [REG_AW-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [REG_AW-1:0]     i_raddr1,
    input  logic [REG_AW-1:0]     i_raddr2,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [DATA_WIDTH-1:0] o_rdata2
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= (RESET_REG_INDEX != 0) ? DATA_WIDTH'(i) : '0;
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_we && i_waddr == i_raddr1) ? i_wdata : r_regs[i_raddr1];
    assign o_rdata2 = (i_we && i_waddr == i_raddr2) ? i_wdata : r_regs[i_raddr2];

endmodule

// File: rtl/id_stage_piped.sv
// ARM decode stage: control decode, condition check, register read with
// bypass, RAW hazard detection and the ID/EX pipeline register.
module id_stage_piped
    import id_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REGS        = 16,
    parameter int RESET_REG_INDEX = 1,
    localparam int REG_AW = ($clog2(NUM_REGS) < 4) ? 4 : $clog2(NUM_REGS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_id_valid,
    input  logic [DATA_WIDTH-1:0] i_pc_in,
    input  logic [31:0]           i_instr_in,
    input  logic [3:0]            i_status_in,
    input  logic                  i_flush,
    input  logic                  i_exe_wb_en,
    input  logic [REG_AW-1:0]     i_exe_dest,
    input  logic                  i_mem_wb_en,
    input  logic [REG_AW-1:0]     i_mem_dest,
    input  logic                  i_wb_en,
    input  logic [REG_AW-1:0]     i_wb_dest,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic                  o_hazard,
    output logic [DATA_WIDTH-1:0] o_ex_pc,
    output logic                  o_ex_mem_read,
    output logic                  o_ex_mem_write,
    output logic                  o_ex_wb_en,
    output logic                  o_ex_branch,
    output logic                  o_ex_s,
    output logic [3:0]            o_ex_cmd,
    output logic [DATA_WIDTH-1:0] o_ex_val_rn,
    output logic [DATA_WIDTH-1:0] o_ex_val_rm,
    output logic                  o_ex_imm,
    output logic [11:0]           o_ex_shift_op,
    output logic [23:0]           o_ex_simm24,
    output logic [REG_AW-1:0]     o_ex_dest,
    output logic [REG_AW-1:0]     o_ex_src1,
    output logic [REG_AW-1:0]     o_ex_src2
);

    ctrl_t                 w_ctrl;
    logic                  w_cond_ok, w_hazard, w_bubble;
    logic [REG_AW-1:0]     w_src1, w_src2;
    logic [DATA_WIDTH-1:0] w_val_rn, w_val_rm;

    ctrl_t                 r_ctrl;
    logic [DATA_WIDTH-1:0] r_pc, r_val_rn, r_val_rm;
    logic                  r_imm;
    logic [11:0]           r_shift_op;
    logic [23:0]           r_simm24;
    logic [REG_AW-1:0]     r_dest, r_src1, r_src2;

    assign w_ctrl    = decode(i_instr_in);
    assign w_cond_ok = cond_pass(i_instr_in[31:28], i_status_in);
    assign w_src1    = REG_AW'(i_instr_in[19:16]);
    assign w_src2    = is_str(i_instr_in) ? REG_AW'(i_instr_in[15:12])
                                          : REG_AW'(i_instr_in[3:0]);

    // A taken branch overrides the stall so IF can fetch the target.
    assign w_hazard = i_id_valid && !i_flush &&
                      raw_hazard(uses_rn(i_instr_in), two_src(i_instr_in),
                                 IDX_W'(w_src1), IDX_W'(w_src2),
                                 i_exe_wb_en, IDX_W'(i_exe_dest),
                                 i_mem_wb_en, IDX_W'(i_mem_dest));
    assign w_bubble = w_hazard || !i_id_valid || !w_cond_ok;
    assign o_hazard = w_hazard;

    reg_file_bypass #(
        .DATA_WIDTH     (DATA_WIDTH),
        .NUM_REGS       (NUM_REGS),
        .RESET_REG_INDEX(RESET_REG_INDEX)
    ) u_rf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (i_wb_en),
        .i_waddr (i_wb_dest),
        .i_wdata (i_wb_data),
        .i_raddr1(w_src1),
        .i_raddr2(w_src2),
        .o_rdata1(w_val_rn),
        .o_rdata2(w_val_rm)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_ctrl     <= '0;
            r_pc       <= '0;
            r_val_rn   <= '0;
            r_val_rm   <= '0;
            r_imm      <= 1'b0;
            r_shift_op <= '0;
            r_simm24   <= '0;
            r_dest     <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
        end else begin
            r_ctrl     <= w_bubble ? '0 : w_ctrl;
            r_pc       <= i_pc_in;
            r_val_rn   <= w_val_rn;
            r_val_rm   <= w_val_rm;
            r_imm      <= i_instr_in[25];
            r_shift_op <= i_instr_in[11:0];
            r_simm24   <= i_instr_in[23:0];
            r_dest     <= REG_AW'(i_instr_in[15:12]);
            r_src1     <= w_src1;
            r_src2     <= w_src2;
        end
    end

    assign o_ex_pc        = r_pc;
    assign o_ex_mem_read  = r_ctrl.mem_read;
    assign o_ex_mem_write = r_ctrl.mem_write;
    assign o_ex_wb_en     = r_ctrl.wb_en;
    assign o_ex_branch    = r_ctrl.branch;
    assign o_ex_s         = r_ctrl.s;
    assign o_ex_cmd       = r_ctrl.cmd;
    assign o_ex_val_rn    = r_val_rn;
    assign o_ex_val_rm    = r_val_rm;
    assign o_ex_imm       = r_imm;
    assign o_ex_shift_op  = r_shift_op;
    assign o_ex_simm24    = r_simm24;
    assign o_ex_dest      = r_dest;
    assign o_ex_src1      = r_src1;
    assign o_ex_src2      = r_src2;

endmodule

// File: tb/tb_id_stage_piped.sv
// Bench for id_stage_piped: directed cases then random traffic against a
// table-driven reference model; a 32-entry register file is checked alone.
module tb_id_stage_piped;

    logic        clk = 1'b0;
    logic        s_rst, s_valid, s_flush, s_exe_wb, s_mem_wb, s_wb_en;
    logic [31:0] s_pc, s_instr, s_wb_data;
    logic [3:0]  s_status, s_exe_dest, s_mem_dest, s_wb_dest;

    logic        o_hazard, o_mr, o_mw, o_wb, o_br, o_s, o_imm;
    logic [31:0] o_pc, o_rn, o_rm;
    logic [3:0]  o_cmd, o_dest, o_src1, o_src2;
    logic [11:0] o_shift;
    logic [23:0] o_simm;

    logic        r32_rst, r32_we;
    logic [4:0]  r32_waddr, r32_raddr1, r32_raddr2;
    logic [31:0] r32_wdata, r32_rd1, r32_rd2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [16];
    int          dp_cmd [16];
    bit          dp_wb  [16];

    always #5 clk = ~clk;

    id_stage_piped dut (
        .i_clk(clk), .i_rst(s_rst), .i_id_valid(s_valid), .i_pc_in(s_pc),
        .i_instr_in(s_instr), .i_status_in(s_status), .i_flush(s_flush),
        .i_exe_wb_en(s_exe_wb), .i_exe_dest(s_exe_dest),
        .i_mem_wb_en(s_mem_wb), .i_mem_dest(s_mem_dest),
        .i_wb_en(s_wb_en), .i_wb_dest(s_wb_dest), .i_wb_data(s_wb_data),
        .o_hazard(o_hazard), .o_ex_pc(o_pc), .o_ex_mem_read(o_mr),
        .o_ex_mem_write(o_mw), .o_ex_wb_en(o_wb), .o_ex_branch(o_br),
        .o_ex_s(o_s), .o_ex_cmd(o_cmd), .o_ex_val_rn(o_rn), .o_ex_val_rm(o_rm),
        .o_ex_imm(o_imm), .o_ex_shift_op(o_shift), .o_ex_simm24(o_simm),
        .o_ex_dest(o_dest), .o_ex_src1(o_src1), .o_ex_src2(o_src2)
    );

    reg_file_bypass #(.DATA_WIDTH(32), .NUM_REGS(32), .RESET_REG_INDEX(1)) u_rf32 (
        .i_clk(clk), .i_rst(r32_rst), .i_we(r32_we), .i_waddr(r32_waddr),
        .i_wdata(r32_wdata), .i_raddr1(r32_raddr1), .i_raddr2(r32_raddr2),
        .o_rdata1(r32_rd1), .o_rdata2(r32_rd2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_match(input logic [3:0] x);
        return (s_exe_wb && s_exe_dest == x) || (s_mem_wb && s_mem_dest == x);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] idx);
        return (s_wb_en && s_wb_dest == idx) ? s_wb_data : m_regs[idx];
    endfunction

    function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0: return z;          1: return !z;
            2: return cy;         3: return !cy;
            4: return n;          5: return !n;
            6: return v;          7: return !v;
            8: return cy && !z;   9: return !cy || z;
            10: return n == v;    11: return n != v;
            12: return !z && n == v;
            13: return z || n != v;
            14: return 1;
            default: return 0;
        endcase
    endfunction

    // One cycle: check hazard on the applied inputs, predict ID/EX, clock, compare.
    task automatic step();
        logic [1:0]  mode;
        logic [3:0]  op, src1, src2;
        bit          str, uses1, uses2, haz, bub, mr, mw, wb, br, s, clr;
        logic [3:0]  cmd;
        #1;
        mode  = s_instr[27:26];
        op    = s_instr[24:21];
        str   = (mode == 2'b01) && !s_instr[20];
        src1  = s_instr[19:16];
        src2  = str ? s_instr[15:12] : s_instr[3:0];
        uses1 = !((mode == 2'b00 && (op == 4'hD || op == 4'hF)) || mode == 2'b10);
        uses2 = !s_instr[25] || str;
        haz   = s_valid && !s_flush &&
                ((uses1 && m_match(src1)) || (uses2 && m_match(src2)));
        chk("hazard", {63'd0, o_hazard}, {63'd0, haz});

        {mr, mw, wb, br, s} = 5'b0;
        cmd = 4'd0;
        if (mode == 2'b00 && dp_cmd[op] >= 0) begin
            cmd = 4'(dp_cmd[op]); wb = dp_wb[op]; s = s_instr[20];
        end else if (mode == 2'b01) begin
            cmd = 4'd2; mr = s_instr[20]; wb = s_instr[20]; mw = !s_instr[20];
        end else if (mode == 2'b10) begin
            br = 1;
        end
        clr = s_rst || s_flush;
        bub = haz || !s_valid || !m_cond(s_instr[31:28], s_status);
        if (clr || bub) begin
            {mr, mw, wb, br, s} = 5'b0;
            cmd = 4'd0;
        end
        begin
            logic [31:0] e_pc, e_rn, e_rm;
            logic [3:0]  e_dest;
            e_pc = s_pc; e_rn = m_read(src1); e_rm = m_read(src2);
            e_dest = s_instr[15:12];
            if (s_rst) begin
                for (int i = 0; i < 16; i++) m_regs[i] = 32'(i);
            end else if (s_wb_en) begin
                m_regs[s_wb_dest] = s_wb_data;
            end
            @(posedge clk);
            #1;
            chk("ctrl", {55'd0, o_mr, o_mw, o_wb, o_br, o_s, o_cmd},
                        {55'd0, mr, mw, wb, br, s, cmd});
            if (clr) begin
                chk("clr_data", {o_pc, o_rn} | {o_rm, 20'd0, o_shift} |
                                {15'd0, o_imm, o_simm, o_dest, o_src1, o_src2, 12'd0}, 64'd0);
            end else if (!bub) begin
                chk("pc", o_pc, e_pc);
                chk("val_rn", o_rn, e_rn);
                chk("val_rm", o_rm, e_rm);
                chk("fields", {o_imm, o_shift, o_simm, o_dest, o_src1, o_src2},
                              {s_instr[25], s_instr[11:0], s_instr[23:0], e_dest, src1, src2});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin dp_cmd[i] = -1; dp_wb[i] = 1; end
        dp_cmd[4'hD] = 1; dp_cmd[4'hF] = 9; dp_cmd[4'h4] = 2; dp_cmd[4'h5] = 3;
        dp_cmd[4'h2] = 4; dp_cmd[4'h6] = 5; dp_cmd[4'h0] = 6; dp_cmd[4'hC] = 7;
        dp_cmd[4'h1] = 8; dp_cmd[4'hA] = 4; dp_cmd[4'h8] = 6;
        dp_wb[4'hA] = 0;  dp_wb[4'h8] = 0;
        for (int i = 0; i < 16; i++) m_regs[i] = 32'hx;

        s_rst = 1; s_valid = 0; s_flush = 0; s_exe_wb = 0; s_mem_wb = 0; s_wb_en = 0;
        s_pc = 32'h4; s_instr = 32'h0; s_status = 4'h0; s_exe_dest = 0; s_mem_dest = 0;
        s_wb_dest = 0; s_wb_data = 0;
        r32_rst = 0; r32_we = 0; r32_waddr = 0; r32_raddr1 = 0; r32_raddr2 = 0; r32_wdata = 0;
        @(posedge clk); #1;
        step();
        chk("rst_wb", {63'd0, o_wb}, 64'd0);

        s_rst = 0; s_valid = 1; s_instr = 32'hE3A01005; s_pc = 32'h8;
        step();
        chk("mov_cmd", {60'd0, o_cmd}, 64'h1);
        chk("mov_dest_shift", {48'd0, o_dest, o_shift}, 64'h1005);

        s_instr = 32'hE0812001; s_exe_wb = 1; s_exe_dest = 4'd1;
        step();
        chk("add_stall", {62'd0, o_hazard, o_wb}, 64'b10);
        s_exe_wb = 0;
        step();
        chk("add_ops", {o_rn, o_rm}, {32'd1, 32'd1});

        s_wb_en = 1; s_wb_dest = 4'd1; s_wb_data = 32'hDEAD;
        step();
        chk("bypass", {o_rn, o_rm}, {32'hDEAD, 32'hDEAD});
        s_wb_en = 0;
        step();
        chk("rf_written", o_rn, 64'hDEAD);

        s_instr = 32'h0A000002; s_status = 4'b0000;
        step();
        chk("beq_nt", {63'd0, o_br}, 64'd0);
        s_status = 4'b0100;
        step();
        chk("beq_t", {39'd0, o_br, o_simm}, {39'd0, 1'b1, 24'h2});

        s_instr = 32'hE5813004; s_status = 0; s_mem_wb = 1; s_mem_dest = 4'd3;
        step();
        chk("str_haz", {63'd0, o_hazard}, 64'd1);
        s_flush = 1;
        step();
        chk("flush_haz", {62'd0, o_hazard, o_mw}, 64'd0);

        s_flush = 0; s_mem_wb = 0; s_instr = 32'hE3510005;
        step();
        chk("cmp", {58'd0, o_s, o_wb, o_cmd}, {58'd0, 2'b10, 4'b0100});

        for (int k = 0; k < 400; k++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(3) != 0) r[31:28] = 4'hE;
            s_instr    = r;
            s_pc       = $urandom;
            s_status   = 4'($urandom);
            s_rst      = ($urandom_range(49) == 0);
            s_flush    = ($urandom_range(11) == 0);
            s_valid    = ($urandom_range(7) != 0);
            s_exe_wb   = ($urandom_range(3) == 0);
            s_mem_wb   = ($urandom_range(3) == 0);
            s_exe_dest = 4'($urandom);
            s_mem_dest = 4'($urandom);
            s_wb_en    = ($urandom_range(1) == 0);
            s_wb_dest  = 4'($urandom);
            s_wb_data  = $urandom;
            step();
        end

        r32_rst = 1;
        @(posedge clk); #1;
        r32_rst = 0; r32_raddr1 = 5'd17; r32_raddr2 = 5'd16;
        #1;
        chk("rf32_rst17", r32_rd1, 64'd17);
        r32_we = 1; r32_waddr = 5'd17; r32_wdata = 32'hCAFE;
        #1;
        chk("rf32_bypass", r32_rd1, 64'hCAFE);
        chk("rf32_other", r32_rd2, 64'd16);
        @(posedge clk); #1;
        r32_we = 0;
        #1;
        chk("rf32_read17", r32_rd1, 64'hCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_piped.md
Name: id_stage_piped

Overview:
- Parametrised ARM instruction-decode stage with its own ID/EX pipeline register.
- Contains the control decoder, condition check, register file with write-through bypass, and a RAW hazard detector.
- Sits between the IF/ID register and the EX stage. Produces registered EX-side controls and operands, plus a combinational stall request back to IF.
- Supports bubble insertion on hazard and flush on a taken branch.

Parameters:
- DATA_WIDTH, 32, width of registers, operands, wb data and PC.
- NUM_REGS, 16, register-file entries; REG_AW = $clog2(NUM_REGS), minimum 4.
- RESET_REG_INDEX, 1, 1: reg[i] resets to i; 0: resets to 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- pc_in  in  DATA_WIDTH  PC+4 from IF/ID.
- instr_in  in  32  instruction word.
- status_in  in  4  {N,Z,C,V} from status register.
- flush  in  1  branch taken in EX; kill current ID instruction.
- exe_wb_en, exe_dest  in  1, REG_AW  writeback info of the instruction in EX.
- mem_wb_en, mem_dest  in  1, REG_AW  writeback info of the instruction in MEM.
- wb_en, wb_dest, wb_data  in  1, REG_AW, DATA_WIDTH  register-file write port.
- hazard  out  1  combinational; stall IF and IF/ID.
- ex_pc  out  DATA_WIDTH  registered.
- ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_s  out  1 each  registered controls.
- ex_cmd  out  4  registered execute command.
- ex_val_rn, ex_val_rm  out  DATA_WIDTH each  registered operands.
- ex_imm  out  1  registered I bit (instr[25]).
- ex_shift_op  out  12  registered instr[11:0].
- ex_simm24  out  24  registered instr[23:0].
- ex_dest  out  REG_AW  registered Rd (instr[15:12]).
- ex_src1, ex_src2  out  REG_AW each  registered source indices, for forwarding.

Behaviour:
- Decode. mode = instr[27:26].
  - Mode 00 data-processing, exe_cmd by opcode[24:21]:
    - MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101
    - AND 0000→0110, ORR 1100→0111, EOR 0001→1000, CMP 1010→0100, TST 1000→0110
    - wb_en=1 except for CMP/TST; s = instr[20].
    - Unlisted opcodes: all controls 0.
  - Mode 01: cmd=0010, s=0. If instr[20]=1 (LDR): mem_read=1, wb_en=1. Else (STR): mem_write=1.
  - Mode 10: branch=1, all other controls 0.
- Condition check: standard ARM 16-code table on status_in. 1111 evaluates false.
- Sources:
  - src1 = instr[19:16].
  - src2 = STR ? instr[15:12] : instr[3:0].
  - uses_rn = not (MOV, MVN or branch).
  - two_src = (~instr[25]) | STR.
- Hazard (combinational), asserted only when id_valid and not flush:
  - hazard = (uses_rn & match(src1)) | (two_src & match(src2)),
  - where match(x) = (exe_wb_en & exe_dest==x) | (mem_wb_en & mem_dest==x).
- Register file:
  - rst loads reg[i] per RESET_REG_INDEX.
  - Write on clk when wb_en.
  - Reads are combinational with bypass: if wb_en and wb_dest equals the read index, return wb_data.
- ID/EX register, priority rst > flush > bubble > load.
  - rst or flush: every ex_* output goes to 0.
  - bubble (hazard or ~id_valid or condition false): all control outputs 0; data fields load but are don't-care.
  - load: capture decoded values.
  - Latency: one cycle from instr_in to ex_* outputs.
- Simultaneous flush and hazard: flush wins; hazard is forced to 0 so IF can take the branch target.
- rst mid-stream: the register file is reinitialised and ID/EX is cleared in the same edge.

Decomposition:
- Package id_pkg holds:
  - mode, opcode and exe_cmd constants;
  - condition-code constants;
  - a packed struct ctrl_t {mem_read, mem_write, wb_en, branch, s, cmd}.
- Sub-module reg_file_bypass (parametrised on DATA_WIDTH, NUM_REGS) holds the register file.
- Decode, condition check and hazard logic are combinational functions in id_pkg.

Test Plan:
- After rst, MOV R1,#5 (0xE3A01005) with id_valid=1 → next cycle ex_wb_en=1, ex_cmd=0001, ex_imm=1, ex_dest=1, ex_shift_op=0x005, hazard=0.
- ADD R2,R1,R1 (0xE0812001) with exe_wb_en=1, exe_dest=1 → hazard=1; next ex_* controls all 0. Drop exe_wb_en → loads ex_cmd=0010, ex_val_rn=ex_val_rm=1.
- Bypass: wb_en=1, wb_dest=1, wb_data=0xDEAD with ADD above, no hazard → ex_val_rn=ex_val_rm=0xDEAD; the following cycle reg[1] reads 0xDEAD.
- BEQ 0x0A000002 with status_in Z=0 → ex_branch=0. With Z=1 → ex_branch=1, ex_simm24=0x000002.
- STR R3,[R1,#4] (0xE5813004) with mem_wb_en=1, mem_dest=3 → hazard=1 (two_src via STR). With flush=1 the same cycle → hazard=0 and ex_* cleared.
- CMP R1,#5 (0xE3510005) → ex_s=1, ex_wb_en=0, ex_cmd=0100. Then NUM_REGS=32 build: index 17 writes and reads back correctly.
